// File: rtl/glm_delta_maxabs.sv
// Largest |FP32| over a stream of delta lines, via a registered compare tree with the line index carried alongside.
// op_done fires log2(VALUES_PER_LINE)+1 cycles after the last line; there is no backpressure and PROCESS accepts in_valid every cycle.
module glm_delta_maxabs #(
  parameter int VALUES_PER_LINE = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           op_start,
  output logic                           op_done,
  input  logic [1:0][31:0]               regs,
  input  logic                           in_valid,
  input  logic [32*VALUES_PER_LINE-1:0]  in_data,
  output logic [31:0]                    max_abs,
  output logic [15:0]                    max_line,
  output logic                           converged,
  output logic                           nan_seen
);

  localparam int         VPL        = VALUES_PER_LINE;
  localparam int         STAGES     = $clog2(VPL);
  localparam int         HALF       = VPL / 2;
  localparam logic [30:0] INF_MAG   = 31'h7F800000;
  localparam logic [2:0] DRAIN_PRE  = 3'(STAGES - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(STAGES);

  typedef enum logic [1:0] {IDLE, PROCESS, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        start_acc, accept, last_acc, done_set;
  logic [15:0] num_lines_in, num_m1, line_cnt;
  logic [30:0] thr_mag;
  logic [2:0]  drain_cnt;

  logic [30:0] lane_mag [VPL];
  logic        line_nan;
  logic        sign_unused;

  logic [30:0] tree_mag [STAGES][HALF];
  logic [30:0] mag_nxt  [STAGES][HALF];
  logic [15:0] tree_idx [STAGES];
  logic [15:0] idx_nxt  [STAGES];
  logic [STAGES-1:0] tree_vld, vld_nxt;
  logic [STAGES-1:0] tree_nan, nan_nxt;

  logic [30:0] run_max, mrg_max;
  logic [15:0] run_idx, mrg_idx;
  logic        run_nan, mrg_nan, take;

  function automatic logic [30:0] max31(input logic [30:0] a, input logic [30:0] b);
    return (a > b) ? a : b;
  endfunction

  assign num_lines_in = regs[0][15:0];

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (op_start) state_nxt = (num_lines_in == 16'd0) ? DRAIN : PROCESS;
      PROCESS: if (last_acc) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_acc = (state == IDLE) && op_start;
    accept    = (state == PROCESS) && in_valid;
    last_acc  = accept && (line_cnt == num_m1);
    done_set  = (state == DRAIN) && (drain_cnt == DRAIN_PRE);
  end

  // Zero-length runs preload the drain counter so they finish one cycle after entering DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_m1    <= '0;
      thr_mag   <= '0;
      line_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_acc) begin
        num_m1   <= num_lines_in - 16'd1;
        thr_mag  <= regs[1][30:0];
        line_cnt <= '0;
      end else if (accept) begin
        line_cnt <= line_cnt + 16'd1;
      end
      if (start_acc)           drain_cnt <= DRAIN_PRE;
      else if (last_acc)       drain_cnt <= '0;
      else if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
    end
  end

  // ---------------- lane magnitudes ----------------
  always_comb begin
    line_nan    = 1'b0;
    sign_unused = ^regs[0][31:16] ^ regs[1][31];
    for (int i = 0; i < VPL; i++) begin
      lane_mag[i] = (in_data[32*i +: 31] > INF_MAG) ? '0 : in_data[32*i +: 31];
      line_nan    = line_nan | (in_data[32*i +: 31] > INF_MAG);
      sign_unused = sign_unused ^ in_data[32*i + 31];
    end
  end

  // ---------------- compare tree ----------------
  always_comb begin
    vld_nxt = '0;
    nan_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      idx_nxt[k] = '0;
      for (int j = 0; j < HALF; j++) mag_nxt[k][j] = '0;
    end
    for (int j = 0; j < HALF; j++) mag_nxt[0][j] = max31(lane_mag[2*j], lane_mag[2*j+1]);
    idx_nxt[0] = line_cnt;
    vld_nxt[0] = accept;
    nan_nxt[0] = line_nan;
    for (int k = 1; k < STAGES; k++) begin
      for (int j = 0; j < HALF/2; j++)
        mag_nxt[k][j] = max31(tree_mag[k-1][2*j], tree_mag[k-1][2*j+1]);
      idx_nxt[k] = tree_idx[k-1];
      vld_nxt[k] = tree_vld[k-1];
      nan_nxt[k] = tree_nan[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tree_mag <= mag_nxt;
    tree_idx <= idx_nxt;
    tree_nan <= nan_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) tree_vld <= '0;
    else       tree_vld <= vld_nxt;
  end

  // ---------------- running max ----------------
  // Strict compare keeps the earliest line on ties.
  always_comb begin
    take    = tree_vld[STAGES-1] && (tree_mag[STAGES-1][0] > run_max);
    mrg_max = take ? tree_mag[STAGES-1][0] : run_max;
    mrg_idx = take ? tree_idx[STAGES-1] : run_idx;
    mrg_nan = run_nan | (tree_vld[STAGES-1] & tree_nan[STAGES-1]);
  end

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      run_max <= '0;
      run_idx <= '0;
      run_nan <= 1'b0;
    end else begin
      run_max <= mrg_max;
      run_idx <= mrg_idx;
      run_nan <= mrg_nan;
    end
  end

  // Results are written on the edge that raises op_done so both become visible together.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_done   <= 1'b0;
      max_abs   <= '0;
      max_line  <= '0;
      converged <= 1'b0;
      nan_seen  <= 1'b0;
    end else begin
      op_done <= done_set;
      if (done_set) begin
        max_abs   <= {1'b0, mrg_max};
        max_line  <= mrg_idx;
        converged <= (mrg_max <= thr_mag);
        nan_seen  <= mrg_nan;
      end
    end
  end

endmodule

// File: tb/tb_glm_delta_maxabs.sv
// Bench for glm_delta_maxabs: fixed vector table, randomized runs against a plain-arithmetic model,
// and hand-written reset / ignored-stimulus sequences.
module tb_glm_delta_maxabs;
  localparam int VPL = 16;

  logic                 clk = 1'b0;
  logic                 reset, op_start, in_valid;
  logic                 op_done;
  logic [1:0][31:0]     regs;
  logic [32*VPL-1:0]    in_data;
  logic [31:0]          max_abs;
  logic [15:0]          max_line;
  logic                 converged, nan_seen;

  glm_delta_maxabs #(.VALUES_PER_LINE(VPL)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_done(op_done), .regs(regs),
    .in_valid(in_valid), .in_data(in_data), .max_abs(max_abs), .max_line(max_line),
    .converged(converged), .nan_seen(nan_seen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int done_cnt = 0, done_cyc = -1;
  logic [31:0] d_max;
  logic [15:0] d_line;
  logic        d_conv, d_nan;

  always @(negedge clk) begin
    if (op_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      d_max  = max_abs;
      d_line = max_line;
      d_conv = converged;
      d_nan  = nan_seen;
    end
  end

  typedef struct {
    int          n;
    logic [31:0] thr, base, spec_val;
    int          spec_line, spec_lane;
    logic [31:0] e_max;
    logic [15:0] e_line;
    bit          e_conv, e_nan;
  } vec_t;

  vec_t vt[8];
  logic [32*VPL-1:0] lines_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] thr, input logic [31:0] base,
                              input logic [31:0] sv, input int sl, input int slane,
                              input logic [31:0] em, input int el, input bit ec, input bit en);
    vec_t v;
    v.n = n; v.thr = thr; v.base = base; v.spec_val = sv; v.spec_line = sl; v.spec_lane = slane;
    v.e_max = em; v.e_line = 16'(el); v.e_conv = ec; v.e_nan = en;
    return v;
  endfunction

  function automatic logic [31:0] rand_lane();
    int r;
    logic [31:0] v;
    r = $urandom_range(0, 999);
    v = $urandom;
    if (r < 16)      v = {v[31], 8'hFF, 23'h400000 | v[22:0]};
    else if (r < 32) v = {v[31], 31'h7F800000};
    else             v[30:23] = 8'(120 + $urandom_range(0, 12));
    return v;
  endfunction

  // Reference: scan lines in order, NaN lanes count as zero, strictly larger wins.
  task automatic model(input logic [31:0] thr, output logic [31:0] m, output logic [15:0] li,
                       output bit conv, output bit nan);
    logic [30:0] mag;
    m = 0; li = 0; nan = 0;
    for (int i = 0; i < lines_q.size(); i++) begin
      for (int l = 0; l < VPL; l++) begin
        mag = lines_q[i][32*l +: 31];
        if (mag > 31'h7F800000) begin
          nan = 1;
          mag = 0;
        end
        if (mag > m[30:0]) begin
          m  = {1'b0, mag};
          li = 16'(i);
        end
      end
    end
    conv = (m[30:0] <= thr[30:0]);
  endtask

  task automatic run_op(input string name, input int n, input logic [31:0] thr, input int max_gap,
                        input bit noise, input logic [31:0] e_max, input logic [15:0] e_line,
                        input bit e_conv, input bit e_nan);
    int start_c, last_c, exp_c, base_cnt, g;
    base_cnt = done_cnt;
    if (noise) begin
      in_valid = 1; in_data = {VPL{32'h7F000000}};
      tick; tick;
    end
    regs[0] = {16'hABCD, 16'(n)};
    regs[1] = thr;
    op_start = 1;
    in_valid = noise;
    start_c = cyc;
    tick;
    op_start = 0; in_valid = 0;
    regs[0] = $urandom; regs[1] = $urandom;
    last_c = start_c;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, max_gap);
      for (int k = 0; k < g; k++) begin
        in_valid = 0;
        op_start = noise && ($urandom_range(0, 3) == 0);
        tick;
      end
      op_start = noise && ($urandom_range(0, 3) == 0);
      in_valid = 1;
      in_data  = lines_q[i];
      last_c   = cyc;
      tick;
    end
    in_valid = 0; op_start = 0;
    if (noise) begin
      for (int k = 0; k < 2; k++) begin
        in_valid = 1; in_data = {VPL{32'h7F700000}}; op_start = 1;
        tick;
      end
      in_valid = 0; op_start = 0;
    end
    exp_c = (n == 0) ? start_c + 2 : last_c + 5;
    for (int k = 0; k < 30 && done_cnt == base_cnt; k++) tick;
    repeat (3) tick;
    check({name, "_done_count"}, 32'(done_cnt - base_cnt), 32'd1);
    check({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_c));
    check({name, "_max_abs"},   d_max, e_max);
    check({name, "_max_line"},  32'(d_line), 32'(e_line));
    check({name, "_converged"}, 32'(d_conv), 32'(e_conv));
    check({name, "_nan_seen"},  32'(d_nan), 32'(e_nan));
    check({name, "_max_hold"},  max_abs, e_max);
  endtask

  task automatic rand_run(input string name, input int n, input int max_gap, input bit noise);
    logic [31:0] thr, em;
    logic [15:0] el;
    bit ec, en;
    logic [32*VPL-1:0] line;
    lines_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < VPL; l++) line[32*l +: 32] = rand_lane();
      lines_q.push_back(line);
    end
    thr = {1'($urandom), 8'(120 + $urandom_range(0, 13)), 23'($urandom)};
    model(thr, em, el, ec, en);
    run_op(name, n, thr, max_gap, noise, em, el, ec, en);
  endtask

  initial begin
    logic [32*VPL-1:0] line;
    int base_cnt;
    reset = 1; op_start = 0; in_valid = 0; in_data = '0; regs = '0;
    repeat (3) tick;
    check("reset_op_done",   32'(op_done), 32'd0);
    check("reset_max_abs",   max_abs, 32'd0);
    check("reset_max_line",  32'(max_line), 32'd0);
    check("reset_converged", 32'(converged), 32'd0);
    check("reset_nan_seen",  32'(nan_seen), 32'd0);
    reset = 0;
    tick;

    vt[0] = mk(3, 32'h3F800000, 32'h3E800000, 32'hC0000000,  1,  7, 32'h40000000, 1, 0, 0);
    vt[1] = mk(2, 32'h3F000000, 32'h3F000000, 32'h3F000000, -1,  0, 32'h3F000000, 0, 1, 0);
    vt[2] = mk(1, 32'h3F800000, 32'h3DCCCCCD, 32'h7FC00000,  0,  0, 32'h3DCCCCCD, 0, 1, 1);
    vt[3] = mk(4, 32'h7F800000, 32'h3F800000, 32'hFF800000,  2, 15, 32'h7F800000, 2, 1, 0);
    vt[4] = mk(2, 32'hBF800000, 32'hBF800000, 32'h00000000, -1,  0, 32'h3F800000, 0, 1, 0);
    vt[5] = mk(5, 32'h00000000, 32'h80000000, 32'h00000000, -1,  0, 32'h00000000, 0, 1, 0);
    vt[6] = mk(0, 32'h3F800000, 32'h00000000, 32'h00000000, -1,  0, 32'h00000000, 0, 1, 0);
    vt[7] = mk(3, 32'h3F000000, 32'h3F000000, 32'h3F000001,  2,  0, 32'h3F000001, 2, 0, 0);

    for (int t = 0; t < 8; t++) begin
      lines_q.delete();
      for (int i = 0; i < vt[t].n; i++) begin
        line = {VPL{vt[t].base}};
        if (i == vt[t].spec_line) line[32*vt[t].spec_lane +: 32] = vt[t].spec_val;
        lines_q.push_back(line);
      end
      run_op($sformatf("vec%0d", t), vt[t].n, vt[t].thr, 0, 0,
             vt[t].e_max, vt[t].e_line, vt[t].e_conv, vt[t].e_nan);
    end

    for (int r = 0; r < 8; r++)
      rand_run($sformatf("rand%0d", r), $urandom_range(1, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    rand_run("gapped100", 100, 4, 1);

    // Abort: reset two cycles after the 2nd of 4 lines; nothing may complete.
    base_cnt = done_cnt;
    regs[0] = 32'd4; regs[1] = 32'h3F800000;
    op_start = 1;
    tick;
    op_start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = {VPL{32'h40400000}};
      tick;
    end
    in_valid = 0;
    tick;
    reset = 1;
    tick; tick;
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = {VPL{32'h40400000}};
      tick;
    end
    in_valid = 0;
    repeat (12) tick;
    check("abort_no_done",   32'(done_cnt - base_cnt), 32'd0);
    check("abort_max_abs",   max_abs, 32'd0);
    check("abort_max_line",  32'(max_line), 32'd0);
    check("abort_converged", 32'(converged), 32'd0);
    check("abort_nan_seen",  32'(nan_seen), 32'd0);

    rand_run("after_reset", 6, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1);
  end

endmodule

// File: doc/glm_delta_maxabs.md
GLM_DELTA_MAXABS -- requirements
Module: glm_delta_maxabs

Interface
REQ-001 SHALL have parameter VALUES_PER_LINE, default 16, giving the number of 32-bit floats per input line; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port op_start, input, 1 bit: one-cycle start pulse.
REQ-005 SHALL have port op_done, output, 1 bit: one-cycle completion pulse.
REQ-006 SHALL have port regs, input, 2 x 32 bits: regs[0][15:0] is num_lines; regs[1] is the threshold as an FP32 bit pattern.
REQ-007 SHALL have port in_valid, input, 1 bit: a delta line is present; there is no backpressure.
REQ-008 SHALL have port in_data, input, 32*VALUES_PER_LINE bits: the delta line; lane i occupies bits [32i+31:32i].
REQ-009 SHALL have port max_abs, output, 32 bits: FP32 bit pattern of the largest |delta| seen, sign bit always 0.
REQ-010 SHALL have port max_line, output, 16 bits: index of the line containing max_abs.
REQ-011 SHALL have port converged, output, 1 bit: max_abs <= threshold.
REQ-012 SHALL have port nan_seen, output, 1 bit: at least one NaN lane was received.

Function
REQ-013 SHALL implement states IDLE, PROCESS and DRAIN.
REQ-014 In IDLE, op_start SHALL:
- latch num_lines and threshold;
- clear the line counter, the running max, max_line and nan_seen;
- move to PROCESS.
REQ-015 In PROCESS and DRAIN, op_start SHALL be ignored.
REQ-016 In IDLE and DRAIN, in_valid SHALL be ignored; no line enters the pipeline.
REQ-017 Lane magnitude SHALL be lane bits [30:0]; all comparisons are unsigned integer compares on these 31 bits.
REQ-018 A lane with magnitude > 0x7F800000 is NaN: it SHALL set nan_seen and contribute magnitude 0.
REQ-019 +/-Inf (magnitude 0x7F800000) SHALL be treated as an ordinary maximum.
REQ-020 The line maximum SHALL use a registered comparator tree of log2(VALUES_PER_LINE) stages, with the line index carried alongside; with the default parameter this is 4 stages.
REQ-021 In the cycle after a line maximum leaves the tree, the running max SHALL update only if the line maximum is strictly greater; on ties the earlier line index is kept.
REQ-022 Line indices SHALL count accepted lines from 0 in PROCESS; when the count reaches num_lines-1 and that line is accepted, the state SHALL move to DRAIN.
REQ-023 DRAIN SHALL wait log2(VALUES_PER_LINE)+1 cycles, then pulse op_done, update the outputs and return to IDLE.
REQ-024 Fixed latency: for the last line accepted at cycle T, op_done SHALL assert at cycle T+log2(VALUES_PER_LINE)+1, which is T+5 at default.
REQ-025 max_abs, max_line, converged and nan_seen SHALL update only in the op_done cycle and hold their values until the next op_done or reset.
REQ-026 converged SHALL equal (max_abs <= threshold[30:0]); the threshold sign bit is ignored.
REQ-027 If num_lines == 0, op_start SHALL go directly to DRAIN and complete with max_abs=0, max_line=0, converged=1, nan_seen=0.
REQ-028 Back-to-back in_valid every cycle SHALL be accepted with no loss.
REQ-029 op_start in the op_done cycle SHALL be ignored; it is accepted from the following cycle.
REQ-030 num_lines up to 65535 SHALL work; the 16-bit line counter never wraps within one operation.

Reset
REQ-031 While reset is high, the block SHALL:
- enter IDLE;
- clear the tree valid bits;
- drive op_done=0, max_abs=0, max_line=0, converged=0, nan_seen=0.
REQ-032 Reset mid-operation SHALL abort it: no op_done is issued, and lines still in flight are discarded.

Verification
REQ-033 Basic run: num_lines=3, threshold=0x3F800000 (1.0), line1 lane7=0xC0000000 (-2.0), all other lanes 0x3E800000 (0.25), lines sent on consecutive cycles T..T+2 -> op_done at T+7, max_abs=0x40000000, max_line=1, converged=0.
REQ-034 Tie and convergence: two lines, both with max 0x3F000000 (0.5), threshold 0x3F000000 -> max_line=0, converged=1.
REQ-035 NaN: a single line with lane0=0x7FC00000 and the other lanes 0x3DCCCCCD -> nan_seen=1, max_abs=0x3DCCCCCD.
REQ-036 Gapped input with ignored stimulus:
- in_valid toggled with random gaps over num_lines=100, plus op_start pulses during PROCESS and in_valid asserted in IDLE;
- required: exactly one op_done, 5 cycles after the 100th accepted line, with the ignored events having no effect.
REQ-037 Reset and zero-length cases:
- reset asserted 2 cycles after the 2nd of 4 lines -> no op_done, outputs 0;
- a new run after reset completes correctly;
- num_lines=0 -> op_done 1 cycle after DRAIN entry, with converged=1.
